// File: rtl/bus_sync_arb_if.sv
// Handshake and bus signals between the source-domain scheduler and its
// requesters plus the destination-side bus_sync.
interface bus_sync_arb_if #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           i_req;
  logic [NUM_REQ*BUS_WIDTH-1:0] i_data;
  logic [NUM_REQ-1:0]           o_gnt;
  logic [NUM_REQ-1:0]           o_done;
  logic [BUS_WIDTH-1:0]         o_bus_data;
  logic                         o_bus_tgl;
  logic                         i_ack_tgl;
  logic                         o_busy;
  logic                         o_err;

  modport master (
    input  i_req, i_data, i_ack_tgl,
    output o_gnt, o_done, o_bus_data, o_bus_tgl, o_busy, o_err
  );

  modport slave (
    output i_req, i_data, i_ack_tgl,
    input  o_gnt, o_done, o_bus_data, o_bus_tgl, o_busy, o_err
  );
endinterface

// File: rtl/bus_sync_arb.sv
// Round-robin scheduler sharing one toggle-strobed multi-bit CDC path among
// NUM_REQ requesters; waits for the echoed toggle and flags a lost ack.
module bus_sync_arb #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  bus_sync_arb_if.master bus
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2,
    ERR      = 2'd3
  } state_t;

  state_t               state_q, state_n;
  logic [PW-1:0]        ptr_q, ptr_n;
  logic [PW-1:0]        cur_q, cur_n;
  logic [CW-1:0]        cnt_q, cnt_n;
  logic [TW-1:0]        tcnt_q, tcnt_n;
  logic [BUS_WIDTH-1:0] data_q, data_n;
  logic                 tgl_q, tgl_n;
  logic                 err_q, err_n;
  logic                 busy_q, busy_n;
  logic [NUM_REQ-1:0]   gnt_q, gnt_n;
  logic [NUM_REQ-1:0]   done_q, done_n;

  logic                 found;
  logic [PW-1:0]        pick;
  int unsigned          arb_idx;

  // First requesting index at or above the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    arb_idx = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_idx = 32'(ptr_q) + i;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (!found && bus.i_req[arb_idx]) begin
        found = 1'b1;
        pick  = PW'(arb_idx);
      end
    end
  end

  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    cur_n   = cur_q;
    cnt_n   = cnt_q;
    tcnt_n  = tcnt_q;
    data_n  = data_q;
    tgl_n   = tgl_q;
    err_n   = err_q;
    gnt_n   = '0;
    done_n  = '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_n[pick] = 1'b1;
          data_n      = bus.i_data[32'(pick)*BUS_WIDTH +: BUS_WIDTH];
          cur_n       = pick;
          ptr_n       = (32'(pick) == NUM_REQ - 1) ? '0 : pick + PW'(1);
          cnt_n       = '0;
          state_n     = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          tgl_n   = ~tgl_q;
          tcnt_n  = '0;
          state_n = WAIT_ACK;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      WAIT_ACK: begin
        if (bus.i_ack_tgl == tgl_q) begin
          done_n[cur_q] = 1'b1;
          state_n       = IDLE;
        end else if (TIMEOUT != 0 && tcnt_q == TW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = ERR;
        end else begin
          tcnt_n = tcnt_q + TW'(1);
        end
      end
      ERR: begin
        state_n = ERR;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      data_q  <= '0;
      tgl_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      cur_q   <= cur_n;
      cnt_q   <= cnt_n;
      tcnt_q  <= tcnt_n;
      data_q  <= data_n;
      tgl_q   <= tgl_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
      gnt_q   <= gnt_n;
      done_q  <= done_n;
    end
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_done     = done_q;
  assign bus.o_bus_data = data_q;
  assign bus.o_bus_tgl  = tgl_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_bus_sync_arb.sv
// Directed vector bench for bus_sync_arb (3 requesters, 8-bit words,
// SETUP_CYC=2, TIMEOUT=16).
module tb_bus_sync_arb;

  typedef struct packed {
    logic [2:0] gnt;
    logic [2:0] done;
    logic [7:0] data;
    logic       tgl;
    logic       busy;
    logic       err;
  } outs_t;

  typedef struct {
    logic       rst;
    logic [2:0] req;
    logic       ack;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_sync_arb_if #(.BUS_WIDTH(8), .NUM_REQ(3)) bif ();

  bus_sync_arb #(
    .BUS_WIDTH(8),
    .NUM_REQ  (3),
    .SETUP_CYC(2),
    .TIMEOUT  (16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bif.master)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  vec_t  vecs[$];

  function automatic outs_t o(logic [2:0] g, logic [2:0] d, logic [7:0] data,
                              logic t, logic b, logic e);
    outs_t r;
    r.gnt = g; r.done = d; r.data = data; r.tgl = t; r.busy = b; r.err = e;
    return r;
  endfunction

  function automatic void add(logic r, logic [2:0] q, logic a, outs_t e);
    vec_t v;
    v.rst = r; v.req = q; v.ack = a; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic outs_t sample();
    outs_t r;
    r.gnt  = bif.o_gnt;
    r.done = bif.o_done;
    r.data = bif.o_bus_data;
    r.tgl  = bif.o_bus_tgl;
    r.busy = bif.o_busy;
    r.err  = bif.o_err;
    return r;
  endfunction

  task automatic check(string name, outs_t exp);
    outs_t act;
    act = sample();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b done=%b data=%h tgl=%b busy=%b err=%b, want gnt=%b done=%b data=%h tgl=%b busy=%b err=%b",
               name, act.gnt, act.done, act.data, act.tgl, act.busy, act.err,
               exp.gnt, exp.done, exp.data, exp.tgl, exp.busy, exp.err);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(logic r, logic [2:0] q, logic a);
    @(negedge clk);
    rst           = r;
    bif.i_req     = q;
    bif.i_ack_tgl = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bif.i_req     = '0;
    bif.i_ack_tgl = 1'b0;
    bif.i_data    = {8'hC3, 8'h3C, 8'hA5};

    // Single request, ack three cycles after toggle
    add(0, 3'b001, 0, o(3'b001, 3'b000, 8'hA5, 0, 1, 0));
    add(0, 3'b000, 0, o(3'b000, 3'b000, 8'hA5, 0, 1, 0));
    add(0, 3'b000, 0, o(3'b000, 3'b000, 8'hA5, 1, 1, 0));
    add(0, 3'b000, 0, o(3'b000, 3'b000, 8'hA5, 1, 1, 0));
    add(0, 3'b000, 0, o(3'b000, 3'b000, 8'hA5, 1, 1, 0));
    add(0, 3'b000, 1, o(3'b000, 3'b001, 8'hA5, 1, 0, 0));
    add(1, 3'b000, 0, o(3'b000, 3'b000, 8'h00, 0, 0, 0));
    // Round robin, all requesting, ack 4 cycles after each toggle
    add(0, 3'b111, 0, o(3'b001, 3'b000, 8'hA5, 0, 1, 0));
    add(0, 3'b111, 0, o(3'b000, 3'b000, 8'hA5, 0, 1, 0));
    for (int i = 0; i < 4; i++) add(0, 3'b111, 0, o(3'b000, 3'b000, 8'hA5, 1, 1, 0));
    add(0, 3'b111, 1, o(3'b000, 3'b001, 8'hA5, 1, 0, 0));
    add(0, 3'b111, 1, o(3'b010, 3'b000, 8'h3C, 1, 1, 0));
    add(0, 3'b111, 1, o(3'b000, 3'b000, 8'h3C, 1, 1, 0));
    for (int i = 0; i < 4; i++) add(0, 3'b111, 1, o(3'b000, 3'b000, 8'h3C, 0, 1, 0));
    add(0, 3'b111, 0, o(3'b000, 3'b010, 8'h3C, 0, 0, 0));
    add(0, 3'b111, 0, o(3'b100, 3'b000, 8'hC3, 0, 1, 0));
    add(0, 3'b111, 0, o(3'b000, 3'b000, 8'hC3, 0, 1, 0));
    for (int i = 0; i < 4; i++) add(0, 3'b111, 0, o(3'b000, 3'b000, 8'hC3, 1, 1, 0));
    add(0, 3'b111, 1, o(3'b000, 3'b100, 8'hC3, 1, 0, 0));
    // Pointer wrap: after requester 2, 101 -> 0 then 2
    add(0, 3'b101, 1, o(3'b001, 3'b000, 8'hA5, 1, 1, 0));
    add(0, 3'b101, 1, o(3'b000, 3'b000, 8'hA5, 1, 1, 0));
    add(0, 3'b101, 1, o(3'b000, 3'b000, 8'hA5, 0, 1, 0));
    add(0, 3'b101, 0, o(3'b000, 3'b001, 8'hA5, 0, 0, 0));
    add(0, 3'b101, 0, o(3'b100, 3'b000, 8'hC3, 0, 1, 0));
    add(0, 3'b000, 0, o(3'b000, 3'b000, 8'hC3, 0, 1, 0));
    add(0, 3'b000, 0, o(3'b000, 3'b000, 8'hC3, 1, 1, 0));
    add(0, 3'b000, 1, o(3'b000, 3'b100, 8'hC3, 1, 0, 0));
    // Spurious ack in IDLE and SETUP, then mismatch and match in WAIT_ACK
    add(0, 3'b000, 0, o(3'b000, 3'b000, 8'hC3, 1, 0, 0));
    add(0, 3'b000, 1, o(3'b000, 3'b000, 8'hC3, 1, 0, 0));
    add(0, 3'b010, 1, o(3'b010, 3'b000, 8'h3C, 1, 1, 0));
    add(0, 3'b000, 0, o(3'b000, 3'b000, 8'h3C, 1, 1, 0));
    add(0, 3'b000, 1, o(3'b000, 3'b000, 8'h3C, 0, 1, 0));
    add(0, 3'b000, 1, o(3'b000, 3'b000, 8'h3C, 0, 1, 0));
    add(0, 3'b000, 0, o(3'b000, 3'b010, 8'h3C, 0, 0, 0));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset", o(3'b000, 3'b000, 8'h00, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].ack);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Timeout: pointer at 0 after requester 2 wrapped? pointer is 2 here; 001 still wins.
    step(0, 3'b001, 0);
    check("to_grant", o(3'b001, 3'b000, 8'hA5, 0, 1, 0));
    step(0, 3'b000, 0);
    step(0, 3'b000, 0);
    check("to_toggle", o(3'b000, 3'b000, 8'hA5, 1, 1, 0));
    for (int k = 1; k <= 15; k++) begin
      step(0, 3'b000, 0);
      if (k == 1 || k == 15) check($sformatf("to_wait%0d", k), o(3'b000, 3'b000, 8'hA5, 1, 1, 0));
    end
    step(0, 3'b000, 0);
    check("to_err", o(3'b000, 3'b000, 8'hA5, 1, 1, 1));
    for (int k = 0; k < 4; k++) begin
      step(0, 3'b001, 1);
      check($sformatf("err_hold%0d", k), o(3'b000, 3'b000, 8'hA5, 1, 1, 1));
    end
    step(1, 3'b000, 0);
    check("err_reset", o(3'b000, 3'b000, 8'h00, 0, 0, 0));

    // Reset one cycle after grant abandons the transfer and rewinds the pointer
    step(0, 3'b010, 0);
    check("mid_grant", o(3'b010, 3'b000, 8'h3C, 0, 1, 0));
    step(1, 3'b000, 0);
    check("mid_reset", o(3'b000, 3'b000, 8'h00, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      step(0, 3'b000, 0);
      check($sformatf("mid_quiet%0d", k), o(3'b000, 3'b000, 8'h00, 0, 0, 0));
    end
    step(0, 3'b110, 0);
    check("mid_regrant", o(3'b010, 3'b000, 8'h3C, 0, 1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
